// File: rtl/cp0_exc_ctrl.sv
// cp0_exc_ctrl: commit-time arbiter between interrupt, exception, eret and
// normal retire, plus the flush/redirect sequencer that restarts fetch.
module cp0_exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'hbfc00380,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter logic [4:0]  INT_EXCCODE  = 5'h00
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_ws_valid,
  input  logic        i_ws_ex,
  input  logic [4:0]  i_ws_exccode,
  input  logic        i_ws_bd,
  input  logic [31:0] i_ws_pc,
  input  logic        i_ws_eret,
  input  logic [31:0] i_cp0_status,
  input  logic [31:0] i_cp0_cause,
  input  logic [31:0] i_cp0_epc,
  input  logic        i_fs_ready,
  output logic        o_wb_ex,
  output logic [4:0]  o_wb_exccode,
  output logic        o_wb_bd,
  output logic [31:0] o_wb_pc,
  output logic        o_eret_reflush,
  output logic        o_flush,
  output logic        o_redirect_valid,
  output logic [31:0] o_redirect_pc,
  output logic        o_ws_allowin
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_FLUSH    = 2'd1,
    S_REDIRECT = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [31:0]        r_target;
  logic [31:0]        w_target_nxt;
  logic               r_int_pend;
  logic               w_int_pend_nxt;
  logic               w_int_raw;
  logic               w_accept;
  logic               w_unused;

  // Unmasked, enabled, non-EXL interrupt request.
  assign w_int_raw = i_cp0_status[0] & ~i_cp0_status[1] &
                     (|(i_cp0_cause[15:8] & i_cp0_status[15:8]));

  // Commit decision point; nothing is accepted while reset is asserted.
  assign w_accept = (r_state == S_IDLE) & i_ws_valid & ~i_rst;

  // Pending interrupt is held at zero whenever the FSM is busy.
  assign w_int_pend_nxt = (w_state_nxt == S_IDLE) & w_int_raw;

  assign w_unused = ^{i_cp0_status[31:16], i_cp0_status[7:2],
                      i_cp0_cause[31:16], i_cp0_cause[7:0]};

  // State, flush counter, redirect target and interrupt sample registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_target   <= '0;
      r_int_pend <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_target   <= w_target_nxt;
      r_int_pend <= w_int_pend_nxt;
    end
  end

  // Next-state, commit strobes and flush/redirect outputs.
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_target_nxt     = r_target;
    o_wb_ex          = 1'b0;
    o_wb_exccode     = 5'h00;
    o_wb_bd          = 1'b0;
    o_wb_pc          = 32'h0;
    o_eret_reflush   = 1'b0;
    o_flush          = 1'b0;
    o_redirect_valid = 1'b0;
    o_redirect_pc    = 32'h0;
    o_ws_allowin     = 1'b0;

    case (r_state)
      S_IDLE: begin
        o_ws_allowin = 1'b1;
        if (w_accept) begin
          if (r_int_pend || i_ws_ex) begin
            o_wb_ex      = 1'b1;
            o_wb_exccode = r_int_pend ? INT_EXCCODE : i_ws_exccode;
            o_wb_bd      = i_ws_bd;
            o_wb_pc      = i_ws_pc;
            w_target_nxt = EXC_VECTOR;
            w_cnt_nxt    = CNT_W'(FLUSH_CYCLES - 1);
            w_state_nxt  = S_FLUSH;
          end else if (i_ws_eret) begin
            o_eret_reflush = 1'b1;
            w_target_nxt   = i_cp0_epc;
            w_cnt_nxt      = CNT_W'(FLUSH_CYCLES - 1);
            w_state_nxt    = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        o_flush = 1'b1;
        if (r_cnt == '0) begin
          w_state_nxt = S_REDIRECT;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_REDIRECT: begin
        o_redirect_valid = 1'b1;
        o_redirect_pc    = r_target;
        if (i_fs_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Bench for cp0_exc_ctrl: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level reference model.
module tb_cp0_exc_ctrl;

  localparam logic [31:0] VEC  = 32'hbfc00380;
  localparam int          FC   = 2;
  localparam logic [4:0]  ICODE = 5'h00;

  logic        clk = 1'b0;
  logic        rst;
  logic        ws_valid, ws_ex, ws_bd, ws_eret, fs_ready;
  logic [4:0]  ws_exccode;
  logic [31:0] ws_pc, cp0_status, cp0_cause, cp0_epc;
  logic        wb_ex, wb_bd, eret_reflush, flush, redirect_valid, ws_allowin;
  logic [4:0]  wb_exccode;
  logic [31:0] wb_pc, redirect_pc;

  int checks   = 0;
  int failures = 0;

  // Reference model: 0 = idle, 1 = flushing, 2 = offering redirect.
  int          m_mode   = 0;
  int          m_left   = 0;
  logic [31:0] m_target = 32'h0;
  logic        m_pend   = 1'b0;

  always #5 clk = ~clk;

  cp0_exc_ctrl dut (
    .i_clk(clk), .i_rst(rst), .i_ws_valid(ws_valid), .i_ws_ex(ws_ex),
    .i_ws_exccode(ws_exccode), .i_ws_bd(ws_bd), .i_ws_pc(ws_pc),
    .i_ws_eret(ws_eret), .i_cp0_status(cp0_status), .i_cp0_cause(cp0_cause),
    .i_cp0_epc(cp0_epc), .i_fs_ready(fs_ready), .o_wb_ex(wb_ex),
    .o_wb_exccode(wb_exccode), .o_wb_bd(wb_bd), .o_wb_pc(wb_pc),
    .o_eret_reflush(eret_reflush), .o_flush(flush),
    .o_redirect_valid(redirect_valid), .o_redirect_pc(redirect_pc),
    .o_ws_allowin(ws_allowin)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare all outputs with the model at the falling edge, then advance the model.
  task automatic check_cycle();
    logic raw, acc, irq, exc, er;
    int   nmode;
    @(negedge clk);
    raw = cp0_status[0] && !cp0_status[1] && ((cp0_cause[15:8] & cp0_status[15:8]) != 8'h00);
    acc = (m_mode == 0) && ws_valid && !rst;
    irq = acc && m_pend;
    exc = acc && !m_pend && ws_ex;
    er  = acc && !m_pend && !ws_ex && ws_eret;
    chk("wb_ex", 32'(wb_ex), 32'(irq || exc));
    chk("wb_exccode", 32'(wb_exccode), irq ? 32'(ICODE) : (exc ? 32'(ws_exccode) : 32'h0));
    chk("wb_bd", 32'(wb_bd), (irq || exc) ? 32'(ws_bd) : 32'h0);
    chk("wb_pc", wb_pc, (irq || exc) ? ws_pc : 32'h0);
    chk("eret_reflush", 32'(eret_reflush), 32'(er));
    chk("flush", 32'(flush), 32'(m_mode == 1));
    chk("redirect_valid", 32'(redirect_valid), 32'(m_mode == 2));
    chk("redirect_pc", redirect_pc, (m_mode == 2) ? m_target : 32'h0);
    chk("ws_allowin", 32'(ws_allowin), 32'(m_mode == 0));

    nmode = m_mode;
    if (rst) begin
      nmode = 0; m_left = 0; m_target = 32'h0;
    end else if (m_mode == 0) begin
      if (irq || exc) begin
        nmode = 1; m_left = FC; m_target = VEC;
      end else if (er) begin
        nmode = 1; m_left = FC; m_target = cp0_epc;
      end
    end else if (m_mode == 1) begin
      m_left = m_left - 1;
      if (m_left == 0) nmode = 2;
    end else begin
      if (fs_ready) nmode = 0;
    end
    m_pend = (!rst && nmode == 0) ? raw : 1'b0;
    m_mode = nmode;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  // Let any in-progress flush/redirect complete, with a bounded wait.
  task automatic drain();
    ws_valid = 1'b0; ws_ex = 1'b0; ws_eret = 1'b0; fs_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (m_mode == 0) break;
      check_cycle();
      adv();
    end
    chk("drain_idle", 32'(m_mode), 32'h0);
    fs_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ws_valid = 1'b0; ws_ex = 1'b0; ws_exccode = 5'h0; ws_bd = 1'b0;
    ws_pc = 32'h0; ws_eret = 1'b0; cp0_status = 32'h0; cp0_cause = 32'h0;
    cp0_epc = 32'h0; fs_ready = 1'b0;
    @(posedge clk); #1;
    check_cycle();
    chk("rst_allowin", 32'(ws_allowin), 32'h1);
    adv();
    rst = 1'b0;

    // Plain retire.
    ws_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check_cycle();
      chk("retire_wb_ex", 32'(wb_ex), 32'h0);
      chk("retire_allowin", 32'(ws_allowin), 32'h1);
      adv();
    end

    // Synchronous exception.
    ws_ex = 1'b1; ws_exccode = 5'h0c; ws_bd = 1'b1; ws_pc = 32'hbfc00104;
    check_cycle();
    chk("exc_wb_ex", 32'(wb_ex), 32'h1);
    chk("exc_code", 32'(wb_exccode), 32'h0c);
    chk("exc_bd", 32'(wb_bd), 32'h1);
    chk("exc_pc", wb_pc, 32'hbfc00104);
    adv();
    ws_ex = 1'b0; ws_bd = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check_cycle();
      chk("exc_flush", 32'(flush), 32'h1);
      chk("exc_no_strobe", 32'(wb_ex), 32'h0);
      adv();
    end
    check_cycle();
    chk("exc_rpc", redirect_pc, 32'hbfc00380);
    adv();
    fs_ready = 1'b1;
    check_cycle();
    adv();
    fs_ready = 1'b0;
    check_cycle();
    chk("exc_back_idle", 32'(ws_allowin), 32'h1);
    adv();

    // Interrupt with one cycle of sampling latency.
    cp0_status = 32'h00400401; cp0_cause = 32'h00000400;
    check_cycle();
    chk("int_latency", 32'(wb_ex), 32'h0);
    adv();
    check_cycle();
    chk("int_taken", 32'(wb_ex), 32'h1);
    chk("int_code", 32'(wb_exccode), 32'h0);
    adv();
    cp0_status = 32'h0;
    drain();
    cp0_status = 32'h00400403; ws_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check_cycle();
      chk("exl_masked", 32'(wb_ex), 32'h0);
      adv();
    end
    cp0_status = 32'h0;

    // Eret with a stalled fetch.
    cp0_epc = 32'hbfc01000; ws_eret = 1'b1;
    check_cycle();
    chk("eret_strobe", 32'(eret_reflush), 32'h1);
    chk("eret_no_ex", 32'(wb_ex), 32'h0);
    adv();
    ws_eret = 1'b0; ws_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin check_cycle(); adv(); end
    for (int i = 0; i < 5; i++) begin
      check_cycle();
      chk("eret_rpc_hold", redirect_pc, 32'hbfc01000);
      chk("eret_rv_hold", 32'(redirect_valid), 32'h1);
      adv();
    end
    drain();

    // Interrupt outranks a simultaneous exception; valid during flush is ignored.
    cp0_status = 32'h00400401; cp0_cause = 32'h00000400;
    check_cycle(); adv();
    ws_valid = 1'b1; ws_ex = 1'b1; ws_exccode = 5'h04; ws_pc = 32'h80001000;
    check_cycle();
    chk("int_over_exc", 32'(wb_exccode), 32'h0);
    adv();
    ws_ex = 1'b0; cp0_status = 32'h0;
    check_cycle();
    chk("flush_ignores_valid", 32'(wb_ex), 32'h0);
    adv();
    drain();

    // Reset in the first flush cycle.
    ws_valid = 1'b1; ws_ex = 1'b1; ws_exccode = 5'h08;
    check_cycle(); adv();
    rst = 1'b1; ws_ex = 1'b0; ws_valid = 1'b0;
    check_cycle(); adv();
    rst = 1'b0;
    check_cycle();
    chk("rst_flush", 32'(flush), 32'h0);
    chk("rst_rv", 32'(redirect_valid), 32'h0);
    chk("rst_idle", 32'(ws_allowin), 32'h1);
    adv();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(0, 99) < 2);
      ws_valid   = ($urandom_range(0, 9) < 7);
      ws_ex      = ($urandom_range(0, 99) < 15);
      ws_exccode = 5'($urandom);
      ws_bd      = 1'($urandom);
      ws_pc      = $urandom;
      ws_eret    = ($urandom_range(0, 99) < 15);
      cp0_status = $urandom;
      cp0_status[0] = ($urandom_range(0, 3) != 0);
      cp0_status[1] = ($urandom_range(0, 3) == 0);
      cp0_cause  = $urandom;
      if ($urandom_range(0, 9) < 7) cp0_cause[15:8] = 8'h00;
      cp0_epc    = $urandom;
      fs_ready   = ($urandom_range(0, 9) < 4);
      check_cycle();
      adv();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cp0_exc_ctrl.md
Name: cp0_exc_ctrl

Overview:
Exception/interrupt commit controller between the writeback stage and the cp0 register block. Once per committed instruction it decides among interrupt, synchronous exception, eret and normal retire. It drives the one-cycle commit strobes that cp0 consumes (wb_ex, wb_exccode, wb_bd, wb_pc, eret_reflush). It then sequences the pipeline flush and the fetch redirect through a small FSM with a ready/valid handshake toward fetch.

Parameters:
EXC_VECTOR, 32'hbfc00380, exception entry PC (status.bev = 1).
FLUSH_CYCLES, 2, cycles flush is held high before redirect is offered (1..15).
INT_EXCCODE, 5'h00, exccode reported for interrupts.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
ws_valid  in  1  writeback holds a valid instruction this cycle
ws_ex  in  1  instruction carries a synchronous exception
ws_exccode  in  5  exception code from the pipeline
ws_bd  in  1  instruction is in a branch delay slot
ws_pc  in  32  instruction PC
ws_eret  in  1  instruction is eret
cp0_status  in  32  status register (bit 0 IE, bit 1 EXL, bits 15:8 IM)
cp0_cause  in  32  cause register (bits 15:8 IP)
cp0_epc  in  32  EPC register
fs_ready  in  1  fetch accepts the redirect
wb_ex  out  1  exception commit strobe to cp0
wb_exccode  out  5  committed exccode
wb_bd  out  1  committed BD flag
wb_pc  out  32  committed PC
eret_reflush  out  1  eret commit strobe to cp0
flush  out  1  kill all in-flight pipeline stages
redirect_valid  out  1  redirect PC offered to fetch
redirect_pc  out  32  redirect target
ws_allowin  out  1  writeback may retire (high only in IDLE)

Behaviour:
- Reset: FSM in IDLE. int_pend_q = 0. flush counter = 0. Every output is 0 except ws_allowin = 1.
- Interrupt sampling:
  - int_raw = status[0] & ~status[1] & |(cause[15:8] & status[15:8]).
  - int_raw is registered into int_pend_q every cycle, giving one cycle of latency.
  - int_pend_q is forced to 0 while the FSM is not IDLE.
- Accept condition: state == IDLE && ws_valid. Priority at accept is interrupt (int_pend_q), then ws_ex, then ws_eret, then normal retire.
- Interrupt or exception accept:
  - wb_ex = 1 for exactly that cycle.
  - wb_exccode = INT_EXCCODE for an interrupt, ws_exccode otherwise.
  - wb_bd = ws_bd and wb_pc = ws_pc, passed through combinationally in the same cycle.
  - Target latched = EXC_VECTOR. Next state FLUSH.
- Eret accept (with no interrupt or exception):
  - eret_reflush = 1 for one cycle.
  - Target latched = cp0_epc sampled in the accept cycle. Next state FLUSH.
  - An eret that also carries ws_ex is handled as an exception only; eret_reflush stays 0.
- Normal retire: no strobes. Stay in IDLE.
- FSM states:
  - IDLE: ws_allowin = 1.
  - FLUSH: flush = 1 and ws_allowin = 0. Counter loads FLUSH_CYCLES-1 on entry and decrements each cycle. Move to REDIRECT when the counter reaches 0. flush is therefore high for exactly FLUSH_CYCLES cycles.
  - REDIRECT: redirect_valid = 1, redirect_pc = latched target, flush = 0, ws_allowin = 0. redirect_pc is held stable until fs_ready. On redirect_valid & fs_ready, go to IDLE on the next edge.
- Strobes are combinational from the accept condition; no strobe ever fires outside IDLE.
- While not IDLE, ws_valid, ws_ex and ws_eret are ignored.
- rst asserted in any state returns the FSM to IDLE on the next edge, drops flush and redirect_valid, and discards the latched target.
- fs_ready high outside REDIRECT has no effect.
- wb_* outputs are 0 when wb_ex = 0.

Test Plan:
- Reset, then ws_valid=1 with no events → wb_ex=0, eret_reflush=0, flush=0, ws_allowin=1 throughout.
- ws_valid=1, ws_ex=1, exccode=5'h0c, bd=1, pc=32'hbfc00104 → wb_ex=1 for 1 cycle with the same fields. flush=1 for 2 cycles. Then redirect_valid=1 with redirect_pc=32'hbfc00380 until fs_ready=1, then IDLE.
- status=32'h00400401, cause=32'h00000400, ws_valid held → one cycle later wb_ex=1 with wb_exccode=0. Repeat with status EXL=1 → no interrupt is taken.
- cp0_epc=32'hbfc01000, ws_eret=1 → eret_reflush=1 for 1 cycle and wb_ex=0. Redirect to 32'hbfc01000. fs_ready held low for 5 cycles → redirect_pc stays stable.
- Interrupt pending plus ws_ex=1 with exccode 5'h04 in the same accept cycle → wb_exccode=0. Second ws_valid during FLUSH → no strobe.
- rst asserted in the first FLUSH cycle → next cycle flush=0, redirect_valid=0, ws_allowin=1.
